led_pwm_seq: RTL and testbench

LED_PWM_SEQ -- requirements
Module: led_pwm_seq

---
 rtl/led_pwm_seq.sv | 128 ++++++++++++
 tb/tb_led_pwm_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_seq.sv
// Multi-channel LED one-shot pulse sequencer: a START edge lights one selected
// channel for its shadowed duty length in CLK cycles, then holds dark until END.
module led_pwm_seq #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned CNT_W      = 24,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_CH*CNT_W-1:0] DUTY,
    input  logic                    DUTY_LD,
    input  logic [NUM_CH-1:0]       CH_SEL,
    input  logic                    START,
    input  logic                    END,
    output logic [NUM_CH-1:0]       LED,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    SEL_ERR
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic LED_ON  = !ACTIVE_LOW;
    localparam logic LED_OFF = ACTIVE_LOW;

    logic [1:0]        state, state_n;
    logic [CNT_W-1:0]  shadow [NUM_CH];
    logic [CNT_W-1:0]  act_duty, act_duty_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [CNT_W-1:0]  sel_duty;
    logic [NUM_CH-1:0] ch_lat, ch_lat_n;
    logic [NUM_CH-1:0] led_n;
    logic              prev_start;
    logic              armed;
    logic              start_rise;
    logic              sel_ok;
    logic              accept;
    logic              sel_bad;
    logic              done_n;

    // armed stays low after reset until START has been sampled low once,
    // so a START held high across reset release cannot fire.
    assign start_rise = START && !prev_start && armed;
    assign sel_ok     = $onehot(CH_SEL);
    assign accept     = start_rise && sel_ok && !END;
    assign sel_bad    = start_rise && !sel_ok && !END;

    always_comb begin
        sel_duty = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (CH_SEL[k]) begin
                sel_duty = sel_duty | shadow[k];
            end
        end
    end

    always_comb begin
        state_n    = state;
        act_duty_n = act_duty;
        cnt_n      = cnt;
        ch_lat_n   = ch_lat;
        done_n     = 1'b0;
        if (END) begin
            state_n = ST_IDLE;
        end else if (accept) begin
            ch_lat_n   = CH_SEL;
            act_duty_n = sel_duty;
            cnt_n      = CNT_W'(1);
            if (sel_duty == '0) begin
                state_n = ST_HOLD;
                done_n  = 1'b1;
            end else begin
                state_n = ST_ON;
            end
        end else if (state == ST_ON) begin
            if (cnt == act_duty) begin
                state_n = ST_HOLD;
                done_n  = 1'b1;
            end else if (cnt != '1) begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        led_n = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            led_n[k] = (state_n == ST_ON && ch_lat_n[k]) ? LED_ON : LED_OFF;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            act_duty   <= '0;
            cnt        <= '0;
            ch_lat     <= '0;
            prev_start <= 1'b0;
            armed      <= 1'b0;
            LED        <= {NUM_CH{LED_OFF}};
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            SEL_ERR    <= 1'b0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                shadow[k] <= '0;
            end
        end else begin
            state      <= state_n;
            act_duty   <= act_duty_n;
            cnt        <= cnt_n;
            ch_lat     <= ch_lat_n;
            prev_start <= START;
            armed      <= armed || !START;
            LED        <= led_n;
            BUSY       <= (state_n != ST_IDLE);
            DONE       <= done_n;
            SEL_ERR    <= SEL_ERR || sel_bad;
            if (DUTY_LD) begin
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    shadow[k] <= DUTY[k*CNT_W +: CNT_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_seq.sv
// Self-checking bench for led_pwm_seq: directed scenarios plus random traffic,
// all outputs compared every cycle against a countdown reference model.
module tb_led_pwm_seq;

    localparam int unsigned NCH = 3;
    localparam int unsigned CW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH*CW-1:0] duty;
    logic            duty_ld;
    logic [NCH-1:0]  ch_sel;
    logic            start;
    logic            end_i;
    logic [NCH-1:0]  led;
    logic            busy;
    logic            done;
    logic            sel_err;

    int checks = 0;
    int errors = 0;

    led_pwm_seq #(
        .NUM_CH    (NCH),
        .CNT_W     (CW),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .DUTY   (duty),
        .DUTY_LD(duty_ld),
        .CH_SEL (ch_sel),
        .START  (start),
        .END    (end_i),
        .LED    (led),
        .BUSY   (busy),
        .DONE   (done),
        .SEL_ERR(sel_err)
    );

    always #5 clk = ~clk;

    // Reference model: remaining on-cycles counted down from the duty value.
    int unsigned    m_shadow [NCH];
    int unsigned    m_left;
    logic [NCH-1:0] m_ch;
    logic           m_busy, m_done, m_err, m_prev, m_armed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic        rise;
        logic        onehot;
        int unsigned d;
        logic [NCH-1:0] exp_led;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NCH; k++) m_shadow[k] = 0;
            m_left = 0; m_ch = '0; m_busy = 0; m_done = 0; m_err = 0;
            m_prev = 0; m_armed = 0;
        end else begin
            rise   = start && !m_prev && m_armed;
            onehot = ($countones(ch_sel) == 1);
            m_done = 0;
            if (end_i) begin
                m_busy = 0;
                m_left = 0;
            end else if (rise && onehot) begin
                d = 0;
                for (int k = 0; k < NCH; k++) if (ch_sel[k]) d = m_shadow[k];
                m_ch   = ch_sel;
                m_left = d;
                m_busy = 1;
                m_done = (d == 0);
            end else if (m_left > 0) begin
                m_left--;
                m_done = (m_left == 0);
            end
            if (rise && !onehot && !end_i) m_err = 1;
            if (duty_ld) for (int k = 0; k < NCH; k++) m_shadow[k] = duty[k*CW +: CW];
            m_prev  = start;
            m_armed = m_armed || !start;
        end
        #1;
        exp_led = (m_left > 0) ? ~m_ch : '1;
        check("led", 32'(led), 32'(exp_led));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("sel_err", 32'(sel_err), 32'(m_err));
    endtask

    // Inputs set before the call apply for the first cycle only (start/duty_ld drop).
    task automatic run_count(input int n, input logic [NCH-1:0] pat,
                             output int on_cnt, output int dn_cnt);
        on_cnt = 0;
        dn_cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            start   = 1'b0;
            duty_ld = 1'b0;
            if (led === pat) on_cnt++;
            if (done === 1'b1) dn_cnt++;
        end
    endtask

    function automatic logic [NCH*CW-1:0] pack(input int r, input int g, input int b);
        return {CW'(b), CW'(g), CW'(r)};
    endfunction

    int on1, on2, dn1, dn2;

    initial begin
        rst = 1'b1; duty = '0; duty_ld = 1'b0; ch_sel = '0; start = 1'b0; end_i = 1'b0;
        m_left = 0; m_ch = '0; m_busy = 0; m_done = 0; m_err = 0; m_prev = 0; m_armed = 0;
        for (int k = 0; k < NCH; k++) m_shadow[k] = 0;
        step(); step();
        check("rst_led", 32'(led), 32'h7);
        rst = 1'b0;

        // Green 5 cycles
        duty = pack(0, 5, 0); duty_ld = 1'b1;
        run_count(1, 3'b101, on1, dn1);
        start = 1'b1; ch_sel = 3'b010;
        run_count(9, 3'b101, on1, dn1);
        check("g5_on_cycles", on1, 5);
        check("g5_done_pulses", dn1, 1);
        check("g5_busy_hold", 32'(busy), 32'h1);
        end_i = 1'b1; step(); end_i = 1'b0;
        check("g5_end_busy", 32'(busy), 32'h0);

        // Red duty 0: straight to HOLD
        start = 1'b1; ch_sel = 3'b001;
        run_count(1, 3'b110, on1, dn1);
        check("r0_done", dn1, 1);
        check("r0_led", 32'(led), 32'h7);
        run_count(3, 3'b110, on1, dn1);
        check("r0_no_on", on1, 0);
        end_i = 1'b1; step(); end_i = 1'b0;

        // Blue 10, aborted on 4th on-cycle
        duty = pack(0, 5, 10); duty_ld = 1'b1;
        run_count(1, 3'b011, on1, dn1);
        start = 1'b1; ch_sel = 3'b100;
        run_count(4, 3'b011, on1, dn1);
        check("b10_on_before_end", on1, 4);
        end_i = 1'b1; step(); end_i = 1'b0;
        check("b10_abort_led", 32'(led), 32'h7);
        check("b10_abort_busy", 32'(busy), 32'h0);
        check("b10_abort_done", 32'(done), 32'h0);

        // Bad selects
        start = 1'b1; ch_sel = 3'b011; run_count(2, 3'b000, on1, dn1);
        start = 1'b1; ch_sel = 3'b000; run_count(3, 3'b000, on1, dn1);
        check("sel_err_set", 32'(sel_err), 32'h1);
        check("sel_err_led", 32'(led), 32'h7);

        // Duty reload mid-pulse does not affect the running pulse
        duty = pack(8, 5, 10); duty_ld = 1'b1;
        run_count(1, 3'b110, on1, dn1);
        start = 1'b1; ch_sel = 3'b001;
        run_count(3, 3'b110, on1, dn1);
        duty = pack(3, 5, 10); duty_ld = 1'b1; ch_sel = 3'b100;
        run_count(8, 3'b110, on2, dn2);
        check("reload_cur_pulse", on1 + on2, 8);
        start = 1'b1; ch_sel = 3'b001;
        run_count(6, 3'b110, on1, dn1);
        check("reload_next_pulse", on1, 3);
        check("sel_err_sticky", 32'(sel_err), 32'h1);

        // Retrigger same channel: no gap
        duty = pack(3, 4, 10); duty_ld = 1'b1;
        run_count(1, 3'b101, on1, dn1);
        start = 1'b1; ch_sel = 3'b010;
        run_count(3, 3'b101, on1, dn1);
        start = 1'b1; ch_sel = 3'b010;
        run_count(7, 3'b101, on2, dn2);
        check("retrig_first", on1, 3);
        check("retrig_second", on2, 4);
        check("retrig_done", dn1 + dn2, 1);

        // Saturating full duty
        duty = pack(3, 15, 10); duty_ld = 1'b1;
        run_count(1, 3'b101, on1, dn1);
        start = 1'b1; ch_sel = 3'b010;
        run_count(18, 3'b101, on1, dn1);
        check("full_on_cycles", on1, 15);
        check("full_done", dn1, 1);
        start = 1'b1; ch_sel = 3'b010;
        run_count(7, 3'b101, on1, dn1);
        check("full_on_before_rst", on1, 7);

        // Reset mid-pulse with START held and DUTY_LD asserted
        rst = 1'b1; start = 1'b1; duty = pack(9, 9, 9); duty_ld = 1'b1;
        step();
        check("rst_mid_led", 32'(led), 32'h7);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_done", 32'(done), 32'h0);
        check("rst_mid_err", 32'(sel_err), 32'h0);
        rst = 1'b0; duty_ld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("held_start_idle", 32'(busy), 32'h0);
        end
        start = 1'b0; run_count(1, 3'b101, on1, dn1);
        start = 1'b1; ch_sel = 3'b010;
        run_count(3, 3'b101, on1, dn1);
        check("rst_shadow_zero_on", on1, 0);
        check("rst_shadow_zero_done", dn1, 1);
        end_i = 1'b1; step(); end_i = 1'b0;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(0, 99) < 2);
            end_i   = ($urandom_range(0, 15) == 0);
            start   = ($urandom_range(0, 2) == 0);
            duty_ld = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) ch_sel = NCH'($urandom_range(0, 7));
            else ch_sel = NCH'(1 << $urandom_range(0, 2));
            for (int k = 0; k < NCH; k++) begin
                case ($urandom_range(0, 5))
                    0: duty[k*CW +: CW] = '0;
                    1: duty[k*CW +: CW] = '1;
                    default: duty[k*CW +: CW] = CW'($urandom_range(1, 9));
                endcase
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
